// File: rtl/ps2_host_cmd_ctrl_if.sv
// Command-side handshake and completion status of the PS/2 host command controller.
// The system drives the command through master; the controller is the slave.
interface ps2_host_cmd_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_byte;
    logic       cmd_has_arg;
    logic [7:0] cmd_arg;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    modport master (
        output cmd_valid, cmd_byte, cmd_has_arg, cmd_arg,
        input  cmd_ready, done, error, err_code
    );

    modport slave (
        input  cmd_valid, cmd_byte, cmd_has_arg, cmd_arg,
        output cmd_ready, done, error, err_code
    );
endinterface

// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host-to-device command sender: inhibit, request-to-send, serialise on device
// clocks, check line ACK, then wait for FA/FE from the receive path with resend.
module ps2_host_cmd_ctrl #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ps2_host_cmd_ctrl_if.slave        cmd_if,
    input  logic                      ps2_clk_in,
    input  logic                      ps2_data_in,
    output logic                      ps2_clk_oe,
    output logic                      ps2_data_oe,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_byte,
    output logic                      rx_enable
);

    localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [7:0] RESP_ACK    = 8'hFA;
    localparam logic [7:0] RESP_RESEND = 8'hFE;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_NACK    = 2'd2;
    localparam logic [1:0] ERR_RETRY   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SEND,
        ST_WAIT_RESP,
        ST_DONE,
        ST_ERROR
    } state_e;

    state_e          state_q, state_nxt;
    logic [IW-1:0]   inh_cnt_q, inh_cnt_nxt;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_nxt;
    logic [3:0]      bit_cnt_q, bit_cnt_nxt;
    logic [RW-1:0]   retry_q, retry_nxt;
    logic            idx_q, idx_nxt;
    logic            has_arg_q, has_arg_nxt;
    logic [7:0]      arg_q, arg_nxt;
    logic [7:0]      cur_byte_q, cur_byte_nxt;
    logic [1:0]      err_code_q, err_code_nxt;
    logic            cmd_ready_q, cmd_ready_nxt;
    logic            clk_oe_q, clk_oe_nxt;
    logic            data_oe_q, data_oe_nxt;
    logic            rx_en_q, rx_en_nxt;
    logic            done_q, done_nxt;
    logic            error_q, error_nxt;

    logic            go_inh;
    logic            go_err;
    logic [1:0]      err_sel;
    logic            tmo_hit;

    // Two-flop synchronisers plus previous-clock flop for falling-edge detect
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_prev_q;
    logic       ps2_fall;
    logic       data_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign ps2_fall = clk_prev_q & ~clk_sync_q[1];
    assign data_s   = data_sync_q[1];

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            inh_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            bit_cnt_q   <= 4'd0;
            retry_q     <= '0;
            idx_q       <= 1'b0;
            has_arg_q   <= 1'b0;
            arg_q       <= 8'h00;
            cur_byte_q  <= 8'h00;
            err_code_q  <= 2'd0;
            cmd_ready_q <= 1'b1;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            rx_en_q     <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            inh_cnt_q   <= inh_cnt_nxt;
            tmo_cnt_q   <= tmo_cnt_nxt;
            bit_cnt_q   <= bit_cnt_nxt;
            retry_q     <= retry_nxt;
            idx_q       <= idx_nxt;
            has_arg_q   <= has_arg_nxt;
            arg_q       <= arg_nxt;
            cur_byte_q  <= cur_byte_nxt;
            err_code_q  <= err_code_nxt;
            cmd_ready_q <= cmd_ready_nxt;
            clk_oe_q    <= clk_oe_nxt;
            data_oe_q   <= data_oe_nxt;
            rx_en_q     <= rx_en_nxt;
            done_q      <= done_nxt;
            error_q     <= error_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        inh_cnt_nxt   = inh_cnt_q;
        tmo_cnt_nxt   = tmo_cnt_q;
        bit_cnt_nxt   = bit_cnt_q;
        retry_nxt     = retry_q;
        idx_nxt       = idx_q;
        has_arg_nxt   = has_arg_q;
        arg_nxt       = arg_q;
        cur_byte_nxt  = cur_byte_q;
        err_code_nxt  = err_code_q;
        cmd_ready_nxt = cmd_ready_q;
        clk_oe_nxt    = clk_oe_q;
        data_oe_nxt   = data_oe_q;
        rx_en_nxt     = rx_en_q;
        done_nxt      = 1'b0;
        error_nxt     = 1'b0;
        go_inh        = 1'b0;
        go_err        = 1'b0;
        err_sel       = 2'd0;
        tmo_hit       = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

        case (state_q)
            ST_IDLE: begin
                if (cmd_if.cmd_valid && cmd_ready_q) begin
                    cur_byte_nxt  = cmd_if.cmd_byte;
                    arg_nxt       = cmd_if.cmd_arg;
                    has_arg_nxt   = cmd_if.cmd_has_arg;
                    idx_nxt       = 1'b0;
                    retry_nxt     = '0;
                    err_code_nxt  = 2'd0;
                    cmd_ready_nxt = 1'b0;
                    go_inh        = 1'b1;
                end
            end

            ST_INHIBIT: begin
                if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
                    state_nxt   = ST_RTS;
                    clk_oe_nxt  = 1'b0;
                    data_oe_nxt = 1'b1;
                    tmo_cnt_nxt = '0;
                    bit_cnt_nxt = 4'd0;
                end else begin
                    inh_cnt_nxt = inh_cnt_q + IW'(1);
                end
            end

            ST_RTS: begin
                tmo_cnt_nxt = tmo_cnt_q + TW'(1);
                if (tmo_hit) begin
                    go_err  = 1'b1;
                    err_sel = ERR_TIMEOUT;
                end else if (ps2_fall) begin
                    state_nxt   = ST_SEND;
                    bit_cnt_nxt = 4'd1;
                    data_oe_nxt = ~cur_byte_q[0];
                end
            end

            // bit_cnt_q holds the number of falling edges already seen
            ST_SEND: begin
                tmo_cnt_nxt = tmo_cnt_q + TW'(1);
                if (tmo_hit) begin
                    go_err  = 1'b1;
                    err_sel = ERR_TIMEOUT;
                end else if (ps2_fall) begin
                    bit_cnt_nxt = bit_cnt_q + 4'd1;
                    case (bit_cnt_q)
                        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
                            data_oe_nxt = ~cur_byte_q[bit_cnt_q[2:0]];
                        4'd8:    data_oe_nxt = ^cur_byte_q;
                        4'd9:    data_oe_nxt = 1'b0;
                        4'd10: begin
                            if (!data_s) begin
                                state_nxt = ST_WAIT_RESP;
                                rx_en_nxt = 1'b1;
                            end else begin
                                go_err  = 1'b1;
                                err_sel = ERR_NACK;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            // A response arriving on the timeout cycle takes priority
            ST_WAIT_RESP: begin
                tmo_cnt_nxt = tmo_cnt_q + TW'(1);
                if (rx_valid && rx_byte == RESP_ACK) begin
                    if (!idx_q && has_arg_q) begin
                        cur_byte_nxt = arg_q;
                        idx_nxt      = 1'b1;
                        retry_nxt    = '0;
                        go_inh       = 1'b1;
                    end else begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end
                end else if (rx_valid && rx_byte == RESP_RESEND) begin
                    if (retry_q == RW'(MAX_RETRY)) begin
                        go_err  = 1'b1;
                        err_sel = ERR_RETRY;
                    end else begin
                        retry_nxt = retry_q + RW'(1);
                        go_inh    = 1'b1;
                    end
                end else if (tmo_hit) begin
                    go_err  = 1'b1;
                    err_sel = ERR_TIMEOUT;
                end
            end

            ST_DONE, ST_ERROR: begin
                state_nxt     = ST_IDLE;
                cmd_ready_nxt = 1'b1;
            end

            default: state_nxt = ST_IDLE;
        endcase

        if (go_inh) begin
            state_nxt   = ST_INHIBIT;
            inh_cnt_nxt = '0;
            clk_oe_nxt  = 1'b1;
            data_oe_nxt = 1'b0;
            rx_en_nxt   = 1'b0;
        end

        if (go_err) begin
            state_nxt    = ST_ERROR;
            error_nxt    = 1'b1;
            err_code_nxt = err_sel;
            clk_oe_nxt   = 1'b0;
            data_oe_nxt  = 1'b0;
            rx_en_nxt    = 1'b1;
        end
    end

    assign ps2_clk_oe       = clk_oe_q;
    assign ps2_data_oe      = data_oe_q;
    assign rx_enable        = rx_en_q;
    assign cmd_if.cmd_ready = cmd_ready_q;
    assign cmd_if.done      = done_q;
    assign cmd_if.error     = error_q;
    assign cmd_if.err_code  = err_code_q;

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Bench for ps2_host_cmd_ctrl: a PS/2 device model captures frames, a transaction-level
// model predicts transmitted bytes and outcome, and a per-cycle monitor checks line rules.
module tb_ps2_host_cmd_ctrl;

    localparam int unsigned TB_INHIBIT = 20;
    localparam int unsigned TB_TIMEOUT = 200;
    localparam int unsigned TB_RETRY   = 3;

    typedef enum int {R_FA, R_FE, R_NACK, R_NONE, R_OTHER} react_e;

    logic clk;
    logic rst_n;
    logic dev_clk;
    logic dev_data;
    logic ps2_clk_in;
    logic ps2_data_in;
    logic ps2_clk_oe;
    logic ps2_data_oe;
    logic rx_valid;
    logic [7:0] rx_byte;
    logic rx_enable;

    ps2_host_cmd_ctrl_if cmd_if ();

    ps2_host_cmd_ctrl #(
        .INHIBIT_CYCLES (TB_INHIBIT),
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .MAX_RETRY      (TB_RETRY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_if      (cmd_if),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .rx_enable   (rx_enable)
    );

    // Open-drain wired-AND of host and device drivers
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int done_seen   = 0;
    int err_seen    = 0;
    logic [1:0] model_code    = 2'd0;
    logic [1:0] exp_code_now  = 2'd0;

    react_e     script [8];
    int         nscript;
    logic [7:0] exp_tx [$];
    logic [7:0] tx_got [$];
    logic [10:0] frames [$];
    int         exp_done;
    logic [1:0] exp_code;
    int         n_used;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle monitor of bus ownership, pulse shape and error-code holding
    initial begin : monitor
        bit pulse_prev;
        int inh_run;
        pulse_prev = 1'b0;
        inh_run    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pulse_prev = 1'b0;
                inh_run    = 0;
            end else begin
                if (ps2_clk_oe || ps2_data_oe) begin
                    check("rx_gate", 32'(rx_enable), 32'd0);
                    check("busy_ready", 32'(cmd_if.cmd_ready), 32'd0);
                end
                if (pulse_prev) begin
                    check("pulse_width", 32'({cmd_if.done, cmd_if.error}), 32'd0);
                    check("ready_after_pulse", 32'(cmd_if.cmd_ready), 32'd1);
                end
                if (ps2_clk_oe) inh_run++;
                else if (inh_run > 0) begin
                    check("inhibit_len", 32'(inh_run), 32'(TB_INHIBIT));
                    check("rts_after_inhibit", 32'(ps2_data_oe), 32'd1);
                    inh_run = 0;
                end
                if (cmd_if.error) begin
                    exp_code_now = model_code;
                    check("err_release", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
                    err_seen++;
                end
                if (cmd_if.done) done_seen++;
                check("err_code_hold", 32'(cmd_if.err_code), 32'(exp_code_now));
                pulse_prev = cmd_if.done | cmd_if.error;
            end
        end
    end

    // Transaction-level prediction of transmitted bytes and final outcome
    task automatic predict(input logic [7:0] c, input bit ha, input logic [7:0] a);
        logic [7:0] cur;
        int idx;
        int retry;
        bit fin;
        cur = c; idx = 0; retry = 0; fin = 1'b0;
        exp_tx.delete();
        exp_done = 0; exp_code = 2'd0; n_used = 0;
        for (int i = 0; i < nscript && !fin; i++) begin
            n_used++;
            case (script[i])
                R_NONE: begin exp_code = 2'd1; fin = 1'b1; end
                R_NACK: begin exp_tx.push_back(cur); exp_code = 2'd2; fin = 1'b1; end
                R_FE: begin
                    exp_tx.push_back(cur);
                    if (retry == int'(TB_RETRY)) begin exp_code = 2'd3; fin = 1'b1; end
                    else retry++;
                end
                default: begin
                    exp_tx.push_back(cur);
                    if (idx == 0 && ha) begin cur = a; idx = 1; retry = 0; end
                    else begin exp_done = 1; fin = 1'b1; end
                end
            endcase
        end
    endtask

    task automatic issue(input logic [7:0] c, input bit ha, input logic [7:0] a, input bit spam);
        @(negedge clk);
        check("ready_idle", 32'(cmd_if.cmd_ready), 32'd1);
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_byte    = c;
        cmd_if.cmd_has_arg = ha;
        cmd_if.cmd_arg     = a;
        @(posedge clk); #1;
        check("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
        check("accept_ready", 32'(cmd_if.cmd_ready), 32'd0);
        exp_code_now     = 2'd0;
        cmd_if.cmd_valid = 1'b0;
        if (spam) begin
            repeat (3) @(negedge clk);
            cmd_if.cmd_valid   = 1'b1;
            cmd_if.cmd_byte    = 8'hAA;
            cmd_if.cmd_has_arg = 1'b1;
            rx_valid = 1'b1;
            rx_byte  = 8'hFA;
            @(negedge clk);
            rx_valid = 1'b0;
            repeat (2) @(negedge clk);
            cmd_if.cmd_valid = 1'b0;
        end
    endtask

    // Device: wait for request-to-send, clock out nfalls edges, sample on rising edges
    task automatic dev_frame(input int nfalls, input bit ack, input bit lat_chk, output logic [10:0] bits);
        int w;
        bits = '1;
        w = 0;
        while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("rts_wait", 32'(w < 1000), 32'd1);
        if (w >= 1000) return;
        repeat (3) @(negedge clk);
        bits[0] = ps2_data_in;
        for (int n = 1; n <= nfalls; n++) begin
            if (n == 11) dev_data = ack ? 1'b0 : 1'b1;
            dev_clk = 1'b0;
            if (lat_chk && n == 1) begin
                repeat (2) @(posedge clk);
                #1 check("edge_lat_before", 32'(ps2_data_oe), 32'd1);
                @(posedge clk);
                #1 check("edge_lat_after", 32'(ps2_data_oe), 32'd0);
                repeat (2) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            dev_clk = 1'b1;
            if (n <= 10) bits[n] = ps2_data_in;
            repeat (4) @(negedge clk);
            if (n == 11) dev_data = 1'b1;
        end
    endtask

    task automatic respond(input logic [7:0] b);
        repeat (3) @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run(input string nm, input logic [7:0] c, input bit ha, input logic [7:0] a,
                       input bit spam, input bit lat);
        int d0;
        int e0;
        int w;
        int k;
        logic [10:0] fb;
        predict(c, ha, a);
        model_code = exp_code;
        tx_got.delete();
        frames.delete();
        d0 = done_seen;
        e0 = err_seen;
        issue(c, ha, a, spam);
        for (int i = 0; i < n_used; i++) begin
            if (script[i] == R_NONE) begin
                w = 0;
                while (ps2_data_oe !== 1'b1 && w < 1000) begin @(posedge clk); #1; w++; end
                k = 0;
                while (cmd_if.error !== 1'b1 && k < 1000) begin @(posedge clk); #1; k++; end
                check({nm, "_timeout_cycles"}, 32'(k), 32'(TB_TIMEOUT));
            end else begin
                dev_frame(11, script[i] != R_NACK, lat && i == 0, fb);
                tx_got.push_back(fb[8:1]);
                frames.push_back(fb);
                check({nm, "_start_bit"}, 32'(fb[0]), 32'd0);
                check({nm, "_odd_parity"}, 32'(^fb[9:1]), 32'd1);
                check({nm, "_stop_bit"}, 32'(fb[10]), 32'd1);
                if (script[i] != R_NACK) begin
                    check({nm, "_rx_en_wait"}, 32'(rx_enable), 32'd1);
                    if (script[i] == R_OTHER) begin
                        respond(8'h1C);
                        repeat (3) @(negedge clk);
                        check({nm, "_other_ignored"}, 32'(done_seen - d0), 32'd0);
                        check({nm, "_still_busy"}, 32'(cmd_if.cmd_ready), 32'd0);
                    end
                    respond(script[i] == R_FE ? 8'hFE : 8'hFA);
                end
            end
        end
        w = 0;
        while (done_seen + err_seen == d0 + e0 && w < 2000) begin @(negedge clk); w++; end
        check({nm, "_outcome_wait"}, 32'(w < 2000), 32'd1);
        repeat (3) @(negedge clk);
        check({nm, "_tx_count"}, 32'(tx_got.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++)
            check({nm, "_tx_byte"}, 32'(tx_got[i]), 32'(exp_tx[i]));
        check({nm, "_done_count"}, 32'(done_seen - d0), 32'(exp_done));
        check({nm, "_err_count"}, 32'(err_seen - e0), 32'(exp_done == 0 ? 1 : 0));
        check({nm, "_err_code"}, 32'(cmd_if.err_code), 32'(exp_code));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors", vectors);
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        logic [10:0] fb;
        rst_n = 1'b0;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        rx_valid = 1'b0;
        rx_byte = 8'h00;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_byte = 8'h00;
        cmd_if.cmd_has_arg = 1'b0;
        cmd_if.cmd_arg = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_rx_enable", 32'(rx_enable), 32'd1);
        check("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("rst_done", 32'(cmd_if.done), 32'd0);
        check("rst_error", 32'(cmd_if.error), 32'd0);
        check("rst_err_code", 32'(cmd_if.err_code), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Set LEDs: ED then argument 02, both answered FA
        script[0] = R_FA; script[1] = R_FA; nscript = 2;
        run("ed02", 8'hED, 1'b1, 8'h02, 1'b0, 1'b1);
        check("ed02_frames", 32'(frames.size()), 32'd2);
        if (frames.size() == 2) begin
            check("ed_frame_bits", 32'(frames[0]), 32'(11'b11111011010));
            check("arg02_frame_bits", 32'(frames[1]), 32'(11'b10000000100));
        end

        // F4 answered FE then FA; busy-time cmd_valid and stray rx_valid ignored
        script[0] = R_FE; script[1] = R_FA; nscript = 2;
        run("f4", 8'hF4, 1'b0, 8'h00, 1'b1, 1'b0);
        check("f4_frames", 32'(frames.size()), 32'd2);
        if (frames.size() == 2)
            check("f4_resend_bits", 32'(frames[1]), 32'(11'b10111101000));

        // Resend limit: FE four times
        for (int i = 0; i < 5; i++) script[i] = R_FE;
        nscript = 5;
        run("fe_limit", 8'hF3, 1'b0, 8'h00, 1'b0, 1'b0);
        check("fe_limit_tx_literal", 32'(tx_got.size()), 32'd4);
        check("fe_limit_code_literal", 32'(cmd_if.err_code), 32'd3);

        // Line-level NACK on the 11th edge
        script[0] = R_NACK; nscript = 1;
        run("nack", 8'hEE, 1'b0, 8'h00, 1'b0, 1'b0);
        check("nack_code_literal", 32'(cmd_if.err_code), 32'd2);

        // Device never clocks
        script[0] = R_NONE; nscript = 1;
        run("timeout", 8'hF2, 1'b0, 8'h00, 1'b0, 1'b0);
        check("timeout_code_literal", 32'(cmd_if.err_code), 32'd1);

        // Reset during bit 5 of ED
        issue(8'hED, 1'b1, 8'h02, 1'b0);
        dev_frame(6, 1'b1, 1'b0, fb);
        rst_n = 1'b0;
        #1;
        check("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("midrst_data_oe", 32'(ps2_data_oe), 32'd0);
        exp_code_now = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("midrst_rx_enable", 32'(rx_enable), 32'd1);

        // Scan code 1C during WAIT_RESP, then FA
        script[0] = R_OTHER; nscript = 1;
        run("scan_then_fa", 8'hF5, 1'b0, 8'h00, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
